// File: rtl/riscv_boot_pkg.sv
// Shared constants for the instruction-memory boot loader: FSM encoding,
// stream framing widths and the word-address helper.
package riscv_boot_pkg;

  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned HDR_BYTES  = 2;

  typedef logic [2:0] boot_state_t;

  localparam boot_state_t S_CNT_LO = 3'd0;
  localparam boot_state_t S_CNT_HI = 3'd1;
  localparam boot_state_t S_DATA   = 3'd2;
  localparam boot_state_t S_DONE   = 3'd3;
  localparam boot_state_t S_ERR    = 3'd4;

  // Byte address of word number idx counted from base.
  function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [15:0] idx);
    return base + (32'(idx) << $clog2(WORD_BYTES));
  endfunction

endpackage

// File: rtl/boot_word_assembler.sv
// Collects little-endian bytes into instruction words; flags the byte that
// completes a word and presents the full word alongside it.
module boot_word_assembler
  import riscv_boot_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      byte_valid,
  input  logic [7:0]                byte_data,
  output logic                      word_ready,
  output logic [8*WORD_BYTES-1:0]   word
);

  localparam int unsigned IdxW = $clog2(WORD_BYTES);

  logic [IdxW-1:0]             byte_idx_q;
  // Only the first WORD_BYTES-1 bytes need storing; the last one is merged live.
  logic [8*(WORD_BYTES-1)-1:0] shift_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      byte_idx_q <= '0;
      shift_q    <= '0;
    end else if (byte_valid) begin
      byte_idx_q <= byte_idx_q + 1'b1;
      shift_q    <= {byte_data, shift_q[8*(WORD_BYTES-1)-1:8]};
    end
  end

  always_comb begin
    word_ready = byte_valid && (byte_idx_q == IdxW'(WORD_BYTES - 1));
    word       = {byte_data, shift_q};
  end

endmodule

// File: rtl/imem_boot_loader.sv
// Fills instruction memory from a byte stream (16-bit word count, then words
// LSB first) and holds the core in reset until the image is complete.
module imem_boot_loader
  import riscv_boot_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        cpu_hold,
  output logic        load_done,
  output logic        load_error
);

  localparam int unsigned CntW = 8 * HDR_BYTES;

  boot_state_t     state_q, state_d;
  logic [CntW-1:0] word_cnt_q, word_cnt_d;
  logic [CntW-1:0] word_idx_q;
  logic [CntW-1:0] hdr_count;

  logic        asm_valid;
  logic        word_ready;
  logic [31:0] word;

  assign asm_valid = rx_valid && (state_q == S_DATA);

  boot_word_assembler u_asm (
    .clk        (clk),
    .reset      (reset),
    .byte_valid (asm_valid),
    .byte_data  (rx_data),
    .word_ready (word_ready),
    .word       (word)
  );

  always_comb begin
    state_d    = state_q;
    word_cnt_d = word_cnt_q;
    hdr_count  = {rx_data, word_cnt_q[7:0]};
    case (state_q)
      S_CNT_LO: begin
        if (rx_valid) begin
          word_cnt_d[7:0] = rx_data;
          state_d         = S_CNT_HI;
        end
      end
      S_CNT_HI: begin
        if (rx_valid) begin
          word_cnt_d = hdr_count;
          if (hdr_count == '0) begin
            state_d = S_DONE;
          end else if (hdr_count > CntW'(DEPTH_WORDS)) begin
            state_d = S_ERR;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        // word_idx has already advanced past the word being written.
        if (imem_we && (word_idx_q == word_cnt_q)) begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_DONE;
      S_ERR:   state_d = S_ERR;
      default: state_d = S_CNT_LO;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_CNT_LO;
      word_cnt_q <= '0;
      word_idx_q <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= BASE_ADDR;
      imem_wdata <= '0;
      cpu_hold   <= 1'b1;
      load_done  <= 1'b0;
      load_error <= 1'b0;
    end else begin
      state_q    <= state_d;
      word_cnt_q <= word_cnt_d;
      imem_we    <= word_ready;
      if (word_ready) begin
        imem_addr  <= word_addr(BASE_ADDR, word_idx_q);
        imem_wdata <= word;
        word_idx_q <= word_idx_q + 1'b1;
      end
      cpu_hold   <= (state_d != S_DONE);
      load_done  <= (state_d == S_DONE);
      load_error <= (state_d == S_ERR);
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Self-checking bench: a stream-position model predicts every output cycle,
// plus literal expectations for each directed scenario.
module tb_imem_boot_loader;

  localparam int unsigned DEPTH = 64;
  localparam logic [31:0] BASE  = 32'h0000_0000;

  logic        clk;
  logic        reset;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_hold;
  logic        load_done;
  logic        load_error;

  imem_boot_loader #(
    .DEPTH_WORDS (DEPTH),
    .BASE_ADDR   (BASE)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_hold   (cpu_hold),
    .load_done  (load_done),
    .load_error (load_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: position in the stream since reset decides everything.
  int          nbytes;
  logic [15:0] m_cnt;
  logic [7:0]  m_bytes [4];
  bit          m_pend;
  logic        m_we, m_hold, m_done, m_err;
  logic [31:0] m_addr, m_wdata;

  int          cyc = 0;
  int          last_byte_edge = -1;
  int          hdr_edge = -1;
  int          last_we_cycle = -1;
  int          done_cycle = -1;
  logic        prev_done = 1'b0;
  logic [31:0] log_addr [$];
  logic [31:0] log_data [$];

  always @(posedge clk) begin
    bit accept;
    int k;
    cyc++;
    if (reset) begin
      nbytes  = 0;
      m_cnt   = '0;
      m_pend  = 0;
      m_we    = 1'b0;
      m_addr  = BASE;
      m_wdata = '0;
      m_hold  = 1'b1;
      m_done  = 1'b0;
      m_err   = 1'b0;
    end else begin
      accept = rx_valid && !m_done && !m_err && !m_pend;
      m_we = 1'b0;
      if (m_pend) begin
        m_pend = 0;
        m_done = 1'b1;
        m_hold = 1'b0;
      end
      if (accept) begin
        last_byte_edge = cyc;
        if (nbytes == 0) begin
          m_cnt[7:0] = rx_data;
        end else if (nbytes == 1) begin
          hdr_edge = cyc;
          m_cnt[15:8] = rx_data;
          if (m_cnt == 0) begin
            m_done = 1'b1;
            m_hold = 1'b0;
          end else if (m_cnt > DEPTH) begin
            m_err = 1'b1;
          end
        end else begin
          k = nbytes - 2;
          m_bytes[k % 4] = rx_data;
          if (k % 4 == 3) begin
            m_we    = 1'b1;
            m_addr  = BASE + 32'(4 * (k / 4));
            m_wdata = {m_bytes[3], m_bytes[2], m_bytes[1], m_bytes[0]};
            if (k / 4 == int'(m_cnt) - 1) m_pend = 1;
          end
        end
        nbytes++;
      end
    end
    #1;
    chk("imem_we", 32'(imem_we), 32'(m_we));
    chk("imem_addr", imem_addr, m_addr);
    chk("imem_wdata", imem_wdata, m_wdata);
    chk("cpu_hold", 32'(cpu_hold), 32'(m_hold));
    chk("load_done", 32'(load_done), 32'(m_done));
    chk("load_error", 32'(load_error), 32'(m_err));
    if (imem_we === 1'b1) begin
      log_addr.push_back(imem_addr);
      log_data.push_back(imem_wdata);
      last_we_cycle = cyc;
    end
    if (load_done === 1'b1 && prev_done !== 1'b1) done_cycle = cyc;
    prev_done = load_done;
  end

  task automatic idle(input int n);
    rx_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int maxgap);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], $urandom_range(0, maxgap));
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    rx_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_imem_we", 32'(imem_we), 32'd0);
    chk("rst_imem_addr", imem_addr, BASE);
    chk("rst_imem_wdata", imem_wdata, 32'd0);
    chk("rst_cpu_hold", 32'(cpu_hold), 32'd1);
    chk("rst_load_done", 32'(load_done), 32'd0);
    chk("rst_load_error", 32'(load_error), 32'd0);
    log_addr.delete();
    log_data.delete();
    done_cycle    = -1;
    last_we_cycle = -1;
  endtask

  logic [7:0] basic [10];

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    basic    = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (2) @(negedge clk);

    // Basic back-to-back load.
    do_reset();
    for (int i = 0; i < 10; i++) send_byte(basic[i], 0);
    idle(4);
    chk("basic_nwrites", 32'(log_addr.size()), 32'd2);
    if (log_addr.size() == 2) begin
      chk("basic_addr0", log_addr[0], 32'h0);
      chk("basic_data0", log_data[0], 32'h0000_0013);
      chk("basic_addr1", log_addr[1], 32'h4);
      chk("basic_data1", log_data[1], 32'h0010_0093);
    end
    chk("basic_done_lat", 32'(done_cycle - last_we_cycle), 32'd1);
    chk("basic_done", 32'(load_done), 32'd1);
    chk("basic_hold", 32'(cpu_hold), 32'd0);

    // Same stream with random gaps.
    do_reset();
    for (int i = 0; i < 10; i++) send_byte(basic[i], $urandom_range(0, 5));
    idle(4);
    chk("gap_nwrites", 32'(log_addr.size()), 32'd2);
    if (log_addr.size() == 2) begin
      chk("gap_addr1", log_addr[1], 32'h4);
      chk("gap_data1", log_data[1], 32'h0010_0093);
    end
    chk("gap_done_lat", 32'(done_cycle - last_byte_edge), 32'd1);

    // Zero word count, trailing byte ignored.
    do_reset();
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    send_byte(8'hAA, 1);
    idle(3);
    chk("zero_nwrites", 32'(log_addr.size()), 32'd0);
    chk("zero_done_lat", 32'(done_cycle - hdr_edge), 32'd0);
    chk("zero_done", 32'(load_done), 32'd1);
    chk("zero_hold", 32'(cpu_hold), 32'd0);

    // Overflow header (65 words).
    do_reset();
    send_byte(8'h41, 0);
    send_byte(8'h00, 0);
    for (int i = 0; i < 20; i++) send_byte(8'(i), 0);
    idle(2);
    chk("ovf_nwrites", 32'(log_addr.size()), 32'd0);
    chk("ovf_error", 32'(load_error), 32'd1);
    chk("ovf_hold", 32'(cpu_hold), 32'd1);
    chk("ovf_done", 32'(load_done), 32'd0);

    // Full-depth load (64 words).
    do_reset();
    send_byte(8'h40, 0);
    send_byte(8'h00, 0);
    for (int i = 0; i < 64; i++) send_word(32'hC0DE_0000 | 32'(i), (i % 8 == 0) ? 2 : 0);
    idle(3);
    chk("full_nwrites", 32'(log_addr.size()), 32'd64);
    if (log_addr.size() == 64) begin
      chk("full_addr_first", log_addr[0], 32'h0);
      chk("full_addr_last", log_addr[63], 32'hFC);
      chk("full_data_last", log_data[63], 32'hC0DE_003F);
    end
    chk("full_done", 32'(load_done), 32'd1);

    // Reset in the middle of a load, then a fresh image.
    do_reset();
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    send_word(32'h1122_3344, 0);
    send_byte(8'h88, 0);
    send_byte(8'h77, 0);
    chk("mid_hold", 32'(cpu_hold), 32'd1);
    do_reset();
    send_byte(8'h02, 0);
    send_byte(8'h00, 1);
    send_word(32'hDEAD_BEEF, 1);
    send_word(32'h1234_5678, 1);
    idle(3);
    chk("rl_nwrites", 32'(log_addr.size()), 32'd2);
    if (log_addr.size() == 2) begin
      chk("rl_addr0", log_addr[0], 32'h0);
      chk("rl_data0", log_data[0], 32'hDEAD_BEEF);
      chk("rl_addr1", log_addr[1], 32'h4);
      chk("rl_data1", log_data[1], 32'h1234_5678);
    end
    chk("rl_done", 32'(load_done), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
